// File: rtl/transfer_sequencer.sv
// transfer_sequencer: top-level sequencer for the UART-to-SD capture path.
// It arms the receive stage, hands the filled FIFO to the drain stage and
// waits for the SD commit. It also latches the error code and the last frame
// CRC, counts committed frames, and exposes a status byte for the display.
//
// Optional feature: define SEQ_WATCHDOG_EN to add a per-state watchdog. Any
// active state that lasts TIMEOUT_CYCLES clocks then goes to ERROR with
// code 4'hF. Without the macro the states wait indefinitely.
module transfer_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sd_init_done,
  input  logic       com_finish,
  input  logic [3:0] com_error,
  input  logic [7:0] com_crc,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  input  logic       out_finish,
  input  logic       sd_write_finish,
  output logic       com_enable,
  output logic       out_enable,
  output logic       busy,
  output logic       done,
  output logic [3:0] error_code,
  output logic [7:0] last_crc,
  output logic [7:0] frame_count,
  output logic [7:0] status
);

  // The display decodes this encoding, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_SD = 3'd1,
    S_RECEIVE = 3'd2,
    S_DRAIN   = 3'd3,
    S_COMMIT  = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] error_code_q, error_code_d;
  logic [7:0] last_crc_q, last_crc_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       com_enable_q, out_enable_q, busy_q, done_q;

`ifdef SEQ_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        wd_active;
`else
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state, error/CRC capture, frame counting and the optional watchdog.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d       = state_q;
    error_code_d  = error_code_q;
    last_crc_d    = last_crc_q;
    frame_count_d = frame_count_q;

    unique case (state_q)
      S_IDLE:    if (start) state_d = S_WAIT_SD;
      S_WAIT_SD: if (sd_init_done) state_d = S_RECEIVE;
      S_RECEIVE: begin
        if (com_finish) last_crc_d = com_crc;
        // An overflow beats a frame completing in the same cycle.
        if (fifo_full) begin
          state_d      = S_ERROR;
          error_code_d = 4'h8;
        end else if (com_finish && (com_error != 4'h0)) begin
          state_d      = S_ERROR;
          error_code_d = {1'b0, com_error[2:0]} | 4'h1;
        end else if (com_finish) begin
          state_d = S_DRAIN;
        end
      end
      // A drain-stage finish only counts once the FIFO is really empty.
      S_DRAIN:   if (fifo_empty && out_finish) state_d = S_COMMIT;
      S_COMMIT:  if (sd_write_finish) state_d = S_DONE;
      S_DONE: begin
        frame_count_d = frame_count_q + 8'd1;
        state_d       = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          state_d      = S_IDLE;
          error_code_d = 4'h0;
        end
      end
      default:   state_d = S_IDLE;
    endcase

`ifdef SEQ_WATCHDOG_EN
    wd_active = (state_q == S_WAIT_SD) || (state_q == S_RECEIVE) ||
                (state_q == S_DRAIN)   || (state_q == S_COMMIT);
    // A real transition on the expiry edge wins over the timeout.
    if (wd_active && (state_d == state_q) &&
        (wd_cnt_q == TIMEOUT_CYCLES - 16'd1)) begin
      state_d      = S_ERROR;
      error_code_d = 4'hF;
    end
    if (state_d != state_q) wd_cnt_d = 16'd0;
    else if (wd_active)     wd_cnt_d = wd_cnt_q + 16'd1;
    else                    wd_cnt_d = 16'd0;
`endif
  end

  // State and Moore outputs. The outputs are decoded from the next state, so
  // they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= S_IDLE;
      error_code_q  <= 4'h0;
      last_crc_q    <= 8'h00;
      frame_count_q <= 8'h00;
      com_enable_q  <= 1'b0;
      out_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt_q      <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      error_code_q  <= error_code_d;
      last_crc_q    <= last_crc_d;
      frame_count_q <= frame_count_d;
      com_enable_q  <= (state_d == S_RECEIVE);
      out_enable_q  <= (state_d == S_DRAIN) || (state_d == S_COMMIT);
      busy_q        <= (state_d != S_IDLE) && (state_d != S_ERROR);
      done_q        <= (state_d == S_DONE);
`ifdef SEQ_WATCHDOG_EN
      wd_cnt_q      <= wd_cnt_d;
`endif
    end
  end

  assign com_enable  = com_enable_q;
  assign out_enable  = out_enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error_code  = error_code_q;
  assign last_crc    = last_crc_q;
  assign frame_count = frame_count_q;
  assign status      = {1'b0, state_q, error_code_q};

endmodule

// File: tb/tb_transfer_sequencer.sv
// Self-checking bench for transfer_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the sequencing rules.
module tb_transfer_sequencer;

  localparam logic [15:0] TO = 16'd16;

  logic       clk = 1'b0;
  logic       reset, start, sd_init_done, com_finish;
  logic [3:0] com_error;
  logic [7:0] com_crc;
  logic       fifo_empty, fifo_full, out_finish, sd_write_finish;
  logic       com_enable, out_enable, busy, done;
  logic [3:0] error_code;
  logic [7:0] last_crc, frame_count, status;

  int checks = 0;
  int errors = 0;

  transfer_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .sd_init_done(sd_init_done),
    .com_finish(com_finish), .com_error(com_error), .com_crc(com_crc),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .out_finish(out_finish),
    .sd_write_finish(sd_write_finish), .com_enable(com_enable),
    .out_enable(out_enable), .busy(busy), .done(done),
    .error_code(error_code), .last_crc(last_crc), .frame_count(frame_count),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase numbers: 0 idle, 1 waiting for card, 2 receiving, 3 draining,
  // 4 committing, 5 frame done, 6 error.
  int         m_phase  = 0;
  logic [3:0] m_err    = 4'h0;
  logic [7:0] m_crc    = 8'h00;
  logic [7:0] m_frames = 8'h00;
  int         m_age    = 0;
  bit         m_valid  = 1'b0;

  always @(posedge clk) begin : model
    int nxt;
    logic [3:0] nerr;
    if (reset) begin
      m_phase = 0; m_err = 4'h0; m_crc = 8'h00; m_frames = 8'h00;
      m_age = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      nxt  = m_phase;
      nerr = m_err;
      case (m_phase)
        0: if (start) nxt = 1;
        1: if (sd_init_done) nxt = 2;
        2: begin
          if (com_finish) m_crc = com_crc;
          if (fifo_full) begin nxt = 6; nerr = 4'h8; end
          else if (com_finish && com_error != 4'h0) begin
            nxt = 6; nerr = {1'b0, com_error[2:0]} | 4'h1;
          end else if (com_finish) nxt = 3;
        end
        3: if (fifo_empty && out_finish) nxt = 4;
        4: if (sd_write_finish) nxt = 5;
        5: begin m_frames = m_frames + 8'd1; nxt = 0; end
        6: if (start) begin nxt = 0; nerr = 4'h0; end
        default: nxt = 0;
      endcase
`ifdef SEQ_WATCHDOG_EN
      if (nxt == m_phase && m_phase >= 1 && m_phase <= 4 && m_age == int'(TO) - 1) begin
        nxt = 6; nerr = 4'hF;
      end
`endif
      m_age   = (nxt != m_phase) ? 0 : m_age + 1;
      m_phase = nxt;
      m_err   = nerr;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("com_enable",  com_enable,  m_phase == 2);
      check("out_enable",  out_enable,  m_phase == 3 || m_phase == 4);
      check("busy",        busy,        m_phase >= 1 && m_phase <= 5);
      check("done",        done,        m_phase == 5);
      check("error_code",  error_code,  m_err);
      check("last_crc",    last_crc,    m_crc);
      check("frame_count", frame_count, m_frames);
      check("status",      status,      {1'b0, 3'(m_phase), m_err});
    end
  end

  // ---------------- stimulus ----------------
  // Advance one clock; returns just after the falling edge, so outputs are
  // settled and new inputs reach the next rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    start = 0; com_finish = 0; com_error = 4'h0; com_crc = 8'h00;
    fifo_full = 0; fifo_empty = 1; out_finish = 0; sd_write_finish = 0;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  // Start a frame and stop once the receive stage is enabled.
  task automatic to_receive();
    sd_init_done = 1; start = 1; step(); start = 0; step();
  endtask

  task automatic full_frame();
    to_receive();
    com_finish = 1; com_error = 4'h0; com_crc = 8'($urandom); step();
    com_finish = 0; fifo_empty = 1; out_finish = 1; step();
    out_finish = 0; sd_write_finish = 1; step();
    sd_write_finish = 0; step();
  endtask

  initial begin
    reset = 1; sd_init_done = 0; idle_inputs();
    step(); reset = 0;
    check("reset status", status, 8'h00);
    check("reset frame_count", frame_count, 8'h00);

    // Happy path
    sd_init_done = 1; start = 1; step(); start = 0;
    check("hp wait_sd com_enable", com_enable, 1'b0);
    check("hp wait_sd status", status, 8'h10);
    step();
    check("hp com_enable at +2", com_enable, 1'b1);
    com_finish = 1; com_crc = 8'hA5; step(); com_finish = 0;
    check("hp out_enable", out_enable, 1'b1);
    check("hp com_enable fell", com_enable, 1'b0);
    check("hp last_crc", last_crc, 8'hA5);
    fifo_empty = 1; out_finish = 1; step(); out_finish = 0;
    check("hp commit status", status, 8'h40);
    sd_write_finish = 1; step(); sd_write_finish = 0;
    check("hp done pulse", done, 1'b1);
    check("hp count before", frame_count, 8'h00);
    step();
    check("hp done cleared", done, 1'b0);
    check("hp frame_count", frame_count, 8'h01);
    check("hp status idle", status, 8'h00);

    // Overflow beats a simultaneous finish
    to_receive();
    fifo_full = 1; com_finish = 1; com_crc = 8'h3C; step();
    fifo_full = 0; com_finish = 0;
    check("ovf error_code", error_code, 4'h8);
    check("ovf status", status, 8'h68);
    check("ovf enables", {com_enable, out_enable}, 2'b00);
    start = 1; step(); start = 0;
    check("ovf cleared status", status, 8'h00);

    // Receive error
    to_receive();
    com_finish = 1; com_error = 4'b0010; com_crc = 8'h11; step(); com_finish = 0;
    check("rx error_code", error_code, 4'h3);
    check("rx enables", {com_enable, out_enable}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      com_finish = 1; com_error = 4'hE; com_crc = 8'(i); step(); com_finish = 0;
    end
    check("rx error held", status, 8'h63);
    check("rx crc held", last_crc, 8'h11);
    com_error = 4'h0; start = 1; step(); start = 0;

    // Drain guard
    to_receive();
    com_finish = 1; step(); com_finish = 0;
    fifo_empty = 0; out_finish = 1;
    step(10);
    check("drain guard status", status, 8'h30);
    fifo_empty = 1; step(); out_finish = 0;
    check("drain to commit", status, 8'h40);

    // Reset mid-drain, then frame counter wrap
    do_reset(); idle_inputs();
    to_receive(); com_finish = 1; step(); com_finish = 0;
    fifo_empty = 0; step();
    reset = 1; step(); reset = 0; fifo_empty = 1;
    check("mid-drain reset enables", {com_enable, out_enable}, 2'b00);
    check("mid-drain reset count", frame_count, 8'h00);
    for (int f = 0; f < 255; f++) full_frame();
    check("count 255", frame_count, 8'hFF);
    full_frame();
    check("count wrap", frame_count, 8'h00);

    // Watchdog (or its absence) while the card never initialises
    sd_init_done = 0; start = 1; step(); start = 0;
`ifdef SEQ_WATCHDOG_EN
    step(15);
    check("wd before expiry", status, 8'h10);
    step();
    check("wd timeout", status, 8'h6F);
    start = 1; step(); start = 0;
`else
    step(1000);
    check("no wd still waiting", status, 8'h10);
    sd_init_done = 1; step();
    check("no wd leaves wait", status, 8'h20);
    do_reset();
`endif

    // Randomized traffic
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 199) == 0);
      start           = ($urandom_range(0, 7) == 0);
      sd_init_done    = ($urandom_range(0, 3) != 0);
      com_finish      = ($urandom_range(0, 7) == 0);
      com_error       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      com_crc         = 8'($urandom);
      fifo_full       = ($urandom_range(0, 31) == 0);
      fifo_empty      = ($urandom_range(0, 1) == 0);
      out_finish      = ($urandom_range(0, 3) == 0);
      sd_write_finish = ($urandom_range(0, 3) == 0);
      step();
    end
    reset = 0; idle_inputs(); step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/transfer_sequencer.md
# transfer_sequencer

Top-level sequencer for the UART-to-SD capture path. It arms the receive stage (COM_to_FIFO), then hands the filled FIFO to the drain stage (FIFO_to_out → SD_Write) and waits for the SD commit. It latches error and CRC status, counts completed frames, and exposes a status byte for the seven-segment display. It replaces the hard-wired always-on enables at the top level and runs on the divided UART clock.

## Interface
- `TIMEOUT_CYCLES`, default 16'd50000: watchdog limit per active state, in `clk` cycles (used only with the watchdog macro).
- `clk` in 1: divided system clock, the same clock as the FIFO and the COM/FIFO stages.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `start` in 1: single-cycle request from the single pulser.
- `sd_init_done` in 1: SD card initialised (level).
- `com_finish` in 1: receive stage finished (one-cycle pulse).
- `com_error` in 4: receive-stage error flags, valid while `com_finish` is high.
- `com_crc` in 8: CRC8 of the frame, valid while `com_finish` is high.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_full` in 1: FIFO full flag.
- `out_finish` in 1: drain stage has emitted its last byte (level or pulse).
- `sd_write_finish` in 1: SD block write committed (pulse).
- `com_enable` out 1: enable to the receive stage.
- `out_enable` out 1: enable to the drain stage.
- `busy` out 1: high in every state except IDLE and ERROR.
- `done` out 1: one-cycle pulse per committed frame.
- `error_code` out 4: latched error code; 0 means no error.
- `last_crc` out 8: CRC captured at the last `com_finish`.
- `frame_count` out 8: committed frames, wraps 255→0.
- `status` out 8: {1'b0, state[2:0], error_code}.

## Operation
- State encoding is fixed: IDLE=0, WAIT_SD=1, RECEIVE=2, DRAIN=3, COMMIT=4, DONE=5, ERROR=6.
- IDLE: `start` → WAIT_SD.
- WAIT_SD: `sd_init_done` → RECEIVE.
- RECEIVE:
  - `fifo_full` → ERROR, code 4'h8.
  - Else `com_finish` with `com_error`≠0 → ERROR, code {1'b0, com_error[2:0]} | 4'h1, so the code is never 0.
  - Else `com_finish` → DRAIN.
  - `last_crc` loads `com_crc` on any `com_finish` seen in RECEIVE.
- DRAIN: `fifo_empty` && `out_finish` → COMMIT. `out_finish` while the FIFO is non-empty is ignored.
- COMMIT: `sd_write_finish` → DONE.
- DONE: `frame_count` increments and `done` is high for this single cycle; next state is IDLE.
- ERROR:
  - All enables are low and `error_code` holds.
  - `start` → IDLE and clears `error_code`.
- `start` is ignored in every state other than IDLE and ERROR.
- Outputs are Moore, decoded from the state register:
  - `com_enable` = (state==RECEIVE).
  - `out_enable` = (state==DRAIN) or (state==COMMIT).
  - `done` = (state==DONE).

## Timing
- Reset (sampled at edge N):
  - From edge N: state IDLE; `com_enable`, `out_enable`, `busy`, `done` = 0; `error_code`, `last_crc`, `frame_count` = 0; `status`=8'h00.
  - Reset mid-transfer drops both enables on the same edge and aborts the frame without counting it.
- `start` high at edge N in IDLE: WAIT_SD from edge N.
  - If `sd_init_done` is already high, RECEIVE from edge N+1, so `com_enable` rises 2 edges after `start`.
- `com_finish` at edge M (no error): DRAIN from edge M. `com_enable` falls and `out_enable` rises on the same edge, with no overlap cycle.
- `sd_write_finish` at edge K: DONE at K, IDLE at K+1. `frame_count` updates at K+1 and `done` is high for cycle K to K+1.
- Simultaneous events:
  - `fifo_full` together with `com_finish` → overflow error wins.
  - `reset` together with any event → reset wins.
- `frame_count` is 8-bit modular; 255 plus one frame gives 0, with no flag.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - A 16-bit counter clears on every state change and increments each cycle in WAIT_SD, RECEIVE, DRAIN and COMMIT.
  - When it equals `TIMEOUT_CYCLES-1` without a transition, the next edge enters ERROR with code 4'hF.
  - A legitimate transition on that same edge takes priority over the timeout.
- `SEQ_WATCHDOG_EN` undefined: no counter; states wait indefinitely. `TIMEOUT_CYCLES` is unused and code 4'hF is never produced.

## Test plan
- Happy path: reset, `sd_init_done`=1, `start` pulse → `com_enable` at +2 cycles; `com_finish`, `com_error`=0, `com_crc`=8'hA5 → `out_enable`=1, `last_crc`=8'hA5; `fifo_empty`&`out_finish`, then `sd_write_finish` → `done` pulse of 1 cycle, `frame_count`=1, `status`=8'h00.
- Overflow: `fifo_full` and `com_finish` in the same RECEIVE cycle → ERROR, `error_code`=4'h8, `status`=8'h68; `start` → `status`=8'h00.
- Receive error: `com_finish` with `com_error`=4'b0010 → `error_code`=4'h3, both enables 0; further `com_finish` pulses → no change.
- Drain guard: `out_finish`=1 while `fifo_empty`=0 for 10 cycles → stays DRAIN; `fifo_empty` rises → COMMIT next edge.
- Reset mid-DRAIN and wrap: reset in DRAIN → enables 0 and `frame_count`=0 at the same edge; then 256 full frames → `frame_count`=0.
- Watchdog, `SEQ_WATCHDOG_EN` with `TIMEOUT_CYCLES`=16: `sd_init_done`=0 after `start` → ERROR with code 4'hF exactly 16 cycles after entering WAIT_SD. Without the macro → still WAIT_SD after 1000 cycles.
